// File: rtl/neo_spike_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | neo_spike_detector                                                       |
// | Streaming NEO spike pre-detector with EMA-adaptive threshold, warm-up    |
// | gating and refractory suppression. Fixed 3-cycle latency.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module neo_spike_detector #(
  parameter int          DATA_W    = 16,
  parameter int          AVG_SHIFT = 10,
  parameter int          THR_SHIFT = 3,
  parameter logic [32:0] MIN_THR   = 33'd1000,
  parameter int          REFRACT   = 50,
  parameter int          WARMUP    = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] data_in,
  output logic                     det_valid,
  output logic                     det_flag,
  output logic signed [2*DATA_W:0] psi_out,
  output logic [31:0]              sample_idx
);

  localparam int c_prod_w = 2 * DATA_W;
  localparam int c_psi_w  = 2 * DATA_W + 1;
  localparam int c_acc_w  = c_psi_w + AVG_SHIFT;
  localparam int c_thr_w  = c_psi_w + THR_SHIFT;
  localparam int c_wu_w   = $clog2(WARMUP + 1);
  localparam int c_rf_w   = $clog2(REFRACT + 1);

  // Stage 0/1: delay line and products
  logic signed [DATA_W-1:0]   r_x1, r_x2;
  logic signed [c_prod_w-1:0] r_sq, r_prod;
  logic                       r_v1, r_v2;
  logic [31:0]                r_idx_cnt, r_idx1, r_idx2;
  logic signed [c_psi_w-1:0]  r_psi;

  // Stage 3 state
  logic [c_acc_w-1:0]         r_acc;
  logic [c_wu_w-1:0]          r_warm;
  logic [c_rf_w-1:0]          r_refr;

  logic signed [c_prod_w-1:0] w_sq, w_prod;
  logic [c_psi_w-1:0]         w_psi_pos;
  logic [c_psi_w-1:0]         w_mean;
  logic [c_thr_w-1:0]         w_thr_scaled, w_thr;
  logic                       w_raw, w_warm, w_det;
  logic [c_acc_w-1:0]         w_acc_next;

  assign w_sq   = c_prod_w'(r_x1) * c_prod_w'(r_x1);
  assign w_prod = c_prod_w'(data_in) * c_prod_w'(r_x2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x1      <= '0;
      r_x2      <= '0;
      r_sq      <= '0;
      r_prod    <= '0;
      r_v1      <= 1'b0;
      r_idx_cnt <= '0;
      r_idx1    <= '0;
    end else begin
      r_v1 <= sample_valid;
      if (sample_valid) begin
        r_x1      <= data_in;
        r_x2      <= r_x1;
        r_sq      <= w_sq;
        r_prod    <= w_prod;
        r_idx1    <= r_idx_cnt;
        r_idx_cnt <= r_idx_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_psi  <= '0;
      r_idx2 <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_psi  <= c_psi_w'(r_sq) - c_psi_w'(r_prod);
        r_idx2 <= r_idx1;
      end
    end
  end

  // Decision uses the threshold derived from acc before this result's update
  assign w_psi_pos    = r_psi[c_psi_w-1] ? '0 : $unsigned(r_psi);
  assign w_mean       = r_acc[c_acc_w-1:AVG_SHIFT];
  assign w_thr_scaled = {w_mean, {THR_SHIFT{1'b0}}};
  assign w_thr        = (w_thr_scaled > c_thr_w'(MIN_THR)) ? w_thr_scaled : c_thr_w'(MIN_THR);
  assign w_raw        = c_thr_w'(w_psi_pos) > w_thr;
  assign w_warm       = (r_warm >= c_wu_w'(WARMUP));
  assign w_det        = w_raw && w_warm && (r_refr == '0);
  assign w_acc_next   = r_acc + c_acc_w'(w_psi_pos) - c_acc_w'(w_mean);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_valid  <= 1'b0;
      det_flag   <= 1'b0;
      psi_out    <= '0;
      sample_idx <= '0;
      r_acc      <= '0;
      r_warm     <= '0;
      r_refr     <= '0;
    end else begin
      det_valid <= r_v2;
      if (r_v2) begin
        det_flag   <= w_det;
        psi_out    <= r_psi;
        sample_idx <= r_idx2;
        r_acc      <= w_acc_next;
        if (!w_warm) begin
          r_warm <= r_warm + 1'b1;
        end
        if (w_det) begin
          r_refr <= c_rf_w'(REFRACT);
        end else if (r_refr != '0) begin
          r_refr <= r_refr - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neo_spike_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_neo_spike_detector                                                    |
// | Directed self-checking bench for neo_spike_detector.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_neo_spike_detector;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_valid;
  logic signed [15:0] data_in;
  logic               det_valid;
  logic               det_flag;
  logic signed [32:0] psi_out;
  logic [31:0]        sample_idx;

  int n_vec = 0;
  int n_err = 0;

  // Results captured in arrival order
  int                 mon_cnt = 0;
  logic signed [32:0] mon_psi  [0:2047];
  logic               mon_flag [0:2047];
  logic [31:0]        mon_idx  [0:2047];

  int                 stim     [0:2047];
  longint             exp_psi  [0:2047];

  neo_spike_detector dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .data_in      (data_in),
    .det_valid    (det_valid),
    .det_flag     (det_flag),
    .psi_out      (psi_out),
    .sample_idx   (sample_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      mon_cnt = 0;
    end else if (det_valid && mon_cnt < 2048) begin
      mon_psi[mon_cnt]  = psi_out;
      mon_flag[mon_cnt] = det_flag;
      mon_idx[mon_cnt]  = sample_idx;
      mon_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic apply_reset();
    rst          = 1'b1;
    sample_valid = 1'b0;
    data_in      = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (det_valid !== 1'b0) begin n_err++; $display("FAIL reset_det_valid: got %b expected 0", det_valid); end
    n_vec++; if (det_flag !== 1'b0) begin n_err++; $display("FAIL reset_det_flag: got %b expected 0", det_flag); end
    n_vec++; if (psi_out !== 33'sd0) begin n_err++; $display("FAIL reset_psi_out: got %0d expected 0", psi_out); end
    n_vec++; if (sample_idx !== 32'd0) begin n_err++; $display("FAIL reset_sample_idx: got %0d expected 0", sample_idx); end
    rst = 1'b0;
  endtask

  // Constant 100: psi = 0 at idx 0, 10000 at idx 1 (x[0]^2 with zero history), then 0
  task automatic test_constant();
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      logic   ev;
      longint ep;
      @(negedge clk);
      ev = (i >= 3 && i < 13);
      ep = (i == 4) ? 64'sd10000 : 64'sd0;
      n_vec++; if (det_valid !== ev) begin n_err++; $display("FAIL const_latency[%0d]: got %b expected %b", i, det_valid, ev); end
      if (ev) begin
        n_vec++; if (sample_idx !== 32'(i - 3)) begin n_err++; $display("FAIL const_idx[%0d]: got %0d expected %0d", i, sample_idx, i - 3); end
        n_vec++; if (psi_out !== 33'(ep)) begin n_err++; $display("FAIL const_psi[%0d]: got %0d expected %0d", i, psi_out, ep); end
        n_vec++; if (det_flag !== 1'b0) begin n_err++; $display("FAIL const_flag[%0d]: got %b expected 0", i, det_flag); end
      end
      sample_valid = (i < 10);
      data_in      = 16'sd100;
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_full_scale();
    int     d  [6];
    longint ep [6];
    d[0] = -32768; d[1] = 32767; d[2] = -32768; d[3] = -32768; d[4] = -32768; d[5] = -32768;
    ep[0] = 0; ep[1] = 1073741824; ep[2] = -65535; ep[3] = 2147450880; ep[4] = 0; ep[5] = 0;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        n_vec++; if (det_valid !== 1'b1) begin n_err++; $display("FAIL fs_valid[%0d]: got %b expected 1", i - 3, det_valid); end
        n_vec++; if (psi_out !== 33'(ep[i-3])) begin n_err++; $display("FAIL fs_psi[%0d]: got %0d expected %0d", i - 3, psi_out, ep[i-3]); end
      end
      sample_valid = (i < 6);
      data_in      = (i < 6) ? 16'(d[i]) : 16'sd0;
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_gaps();
    logic   v  [5];
    int     d  [5];
    int     ei [5];
    longint ep [5];
    longint last_psi;
    int     last_idx;
    v[0] = 1; v[1] = 0; v[2] = 1; v[3] = 1; v[4] = 0;
    d[0] = 5; d[1] = 1000; d[2] = 7; d[3] = 9; d[4] = 1000;
    ei[0] = 0; ei[1] = 0; ei[2] = 1; ei[3] = 2; ei[4] = 2;
    ep[0] = 0; ep[1] = 0; ep[2] = 25; ep[3] = 4; ep[4] = 4;
    last_psi = 0;
    last_idx = 0;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      logic ev;
      @(negedge clk);
      ev = (i >= 3 && i < 8) ? v[i-3] : 1'b0;
      n_vec++; if (det_valid !== ev) begin n_err++; $display("FAIL gap_valid[%0d]: got %b expected %b", i, det_valid, ev); end
      if (i >= 3 && i < 8) begin
        last_psi = ep[i-3];
        last_idx = ei[i-3];
      end
      if (i >= 3) begin
        n_vec++; if (sample_idx !== 32'(last_idx)) begin n_err++; $display("FAIL gap_idx[%0d]: got %0d expected %0d", i, sample_idx, last_idx); end
        n_vec++; if (psi_out !== 33'(last_psi)) begin n_err++; $display("FAIL gap_psi[%0d]: got %0d expected %0d", i, psi_out, last_psi); end
      end
      sample_valid = (i < 5) ? v[i] : 1'b0;
      data_in      = (i < 5) ? 16'(d[i]) : 16'sd0;
    end
    sample_valid = 1'b0;
  endtask

  task automatic run_stream(input int len);
    int bx1, bx2;
    bx1 = 0;
    bx2 = 0;
    apply_reset();
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      data_in      = 16'(stim[i]);
      exp_psi[i]   = longint'(bx1) * bx1 - longint'(stim[i]) * bx2;
      bx2 = bx1;
      bx1 = stim[i];
    end
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (6) @(negedge clk);
    n_vec++; if (mon_cnt !== len) begin n_err++; $display("FAIL stream_count: got %0d expected %0d", mon_cnt, len); end
  endtask

  task automatic test_warmup_spike();
    for (int i = 0; i < 600; i++) stim[i] = (i == 500) ? 20000 : ((i % 2 == 0) ? 10 : -10);
    run_stream(600);
    for (int i = 0; i < 600 && i < mon_cnt; i++) begin
      n_vec++; if (mon_flag[i] !== 1'b0) begin n_err++; $display("FAIL warm_flag[%0d]: got %b expected 0", i, mon_flag[i]); end
    end
    n_vec++; if (mon_psi[501] !== 33'(exp_psi[501])) begin n_err++; $display("FAIL warm_psi501: got %0d expected %0d", mon_psi[501], exp_psi[501]); end
    n_vec++; if (dut.r_acc === '0) begin n_err++; $display("FAIL warm_acc: got 0 expected nonzero"); end
  endtask

  // Spike at 1100 flags at 1101; 1110 lands in refractory; 1160 flags at 1161
  task automatic test_spike_refractory();
    for (int i = 0; i < 1180; i++) begin
      if (i < 1100) stim[i] = (i % 2 == 0) ? 10 : -10;
      else if (i == 1100 || i == 1110 || i == 1160) stim[i] = 20000;
      else stim[i] = -10;
    end
    run_stream(1180);
    for (int i = 0; i < 1180 && i < mon_cnt; i++) begin
      logic ef;
      ef = (i == 1101 || i == 1161);
      n_vec++; if (mon_idx[i] !== 32'(i)) begin n_err++; $display("FAIL spk_idx[%0d]: got %0d expected %0d", i, mon_idx[i], i); end
      n_vec++; if (mon_psi[i] !== 33'(exp_psi[i])) begin n_err++; $display("FAIL spk_psi[%0d]: got %0d expected %0d", i, mon_psi[i], exp_psi[i]); end
      n_vec++; if (mon_flag[i] !== ef) begin n_err++; $display("FAIL spk_flag[%0d]: got %b expected %b", i, mon_flag[i], ef); end
    end
    n_vec++; if (mon_psi[1100] !== -33'sd199900) begin n_err++; $display("FAIL spk_psi_k: got %0d expected -199900", mon_psi[1100]); end
    n_vec++; if (mon_psi[1101] !== 33'sd399999900) begin n_err++; $display("FAIL spk_psi_k1: got %0d expected 399999900", mon_psi[1101]); end
  endtask

  task automatic test_reset_flush();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sample_valid = (i < 4);
      data_in      = 16'(10 * (i + 1));
    end
    n_vec++; if (det_valid !== 1'b1 || sample_idx !== 32'd1) begin n_err++; $display("FAIL flush_pre: got valid %b idx %0d expected 1 1", det_valid, sample_idx); end
    n_vec++; if (psi_out !== 33'sd100) begin n_err++; $display("FAIL flush_pre_psi: got %0d expected 100", psi_out); end
    rst          = 1'b1;
    sample_valid = 1'b0;
    #1;
    n_vec++; if (det_valid !== 1'b0) begin n_err++; $display("FAIL flush_rst_valid: got %b expected 0", det_valid); end
    n_vec++; if (psi_out !== 33'sd0) begin n_err++; $display("FAIL flush_rst_psi: got %0d expected 0", psi_out); end
    n_vec++; if (sample_idx !== 32'd0) begin n_err++; $display("FAIL flush_rst_idx: got %0d expected 0", sample_idx); end
    n_vec++; if (det_flag !== 1'b0) begin n_err++; $display("FAIL flush_rst_flag: got %b expected 0", det_flag); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (det_valid !== 1'b0) begin n_err++; $display("FAIL flush_hold[%0d]: got %b expected 0", i, det_valid); end
    end
    rst          = 1'b0;
    sample_valid = 1'b1;
    data_in      = 16'sd3;
    for (int j = 1; j < 7; j++) begin
      logic ev;
      @(negedge clk);
      sample_valid = (j == 1);
      data_in      = 16'sd4;
      ev = (j == 3 || j == 4);
      n_vec++; if (det_valid !== ev) begin n_err++; $display("FAIL flush_post_valid[%0d]: got %b expected %b", j, det_valid, ev); end
      if (j == 3) begin
        n_vec++; if (sample_idx !== 32'd0) begin n_err++; $display("FAIL flush_post_idx0: got %0d expected 0", sample_idx); end
      end
      if (j == 4) begin
        n_vec++; if (sample_idx !== 32'd1) begin n_err++; $display("FAIL flush_post_idx1: got %0d expected 1", sample_idx); end
        n_vec++; if (psi_out !== 33'sd9) begin n_err++; $display("FAIL flush_post_psi: got %0d expected 9", psi_out); end
      end
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    data_in      = '0;
    test_reset();
    test_constant();
    test_full_scale();
    test_gaps();
    test_warmup_spike();
    test_spike_refractory();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
